// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8N1 UART receiver FSM driving receive-data/control register write enables.
// Bits are sampled mid-cell from a 2-flop synchronized copy of the line.
module uart_rx_ctrl #(
    parameter int DIV = 868
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    input  logic       rx_pending_i,
    output logic [7:0] data_o,
    output logic       we_data_o,
    output logic       we_ctrl_o,
    output logic       ferr_o,
    output logic       overrun_o,
    output logic       busy_o
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_FERR  = 3'd5;
    localparam logic [2:0] S_WAIT  = 3'd6;

    logic [1:0]    r_sync;
    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          w_rx_s;

    assign w_rx_s = r_sync[1];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_sync  <= 2'b11;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
        end else begin
            r_sync <= {r_sync[0], rx_i};
            case (r_state)
                S_IDLE: if (!w_rx_s) begin
                    r_state <= S_START;
                    r_cnt   <= '0;
                end
                S_START: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == HALF) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= w_rx_s ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == FULL) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        r_idx   <= r_idx + 3'd1;
                        if (r_idx == 3'd7) r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == FULL) begin
                        r_cnt   <= '0;
                        r_state <= w_rx_s ? S_WRITE : S_FERR;
                        // Loaded here so data_o already shows the byte during the WRITE pulse
                        if (w_rx_s) r_data <= r_shift;
                    end
                end
                S_WRITE: r_state <= S_IDLE;
                S_FERR:  r_state <= S_WAIT;
                S_WAIT:  if (w_rx_s) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign data_o    = r_data;
    assign we_data_o = r_state == S_WRITE;
    assign we_ctrl_o = r_state == S_WRITE;
    assign overrun_o = (r_state == S_WRITE) && rx_pending_i;
    assign ferr_o    = r_state == S_FERR;
    assign busy_o    = r_state != S_IDLE;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench; stimulus pushes expected events, a negedge monitor pops and checks them.
module tb_uart_rx_ctrl;
    localparam int DIV = 16;

    typedef struct {
        bit         is_ferr;
        logic [7:0] data;
        bit         ovr;
    } exp_t;

    logic       clk = 0;
    logic       rst_n = 0;
    logic       rx = 1;
    logic       pend = 0;
    logic [7:0] data_o;
    logic       we_data_o, we_ctrl_o, ferr_o, overrun_o, busy_o;

    exp_t       exp_q[$];
    exp_t       e;
    int         wcyc[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    logic [7:0] last_data = 8'h00;

    uart_rx_ctrl #(.DIV(DIV)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx), .rx_pending_i(pend),
        .data_o(data_o), .we_data_o(we_data_o), .we_ctrl_o(we_ctrl_o),
        .ferr_o(ferr_o), .overrun_o(overrun_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic check_rng(input string name, input int v, input int lo, input int hi);
        tests++;
        if (v < lo || v > hi) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
        end
    endtask

    task automatic tk(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Reference model: a good stop bit yields a write of the byte, a bad one a framing error
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit p);
        exp_t x;
        pend = p;
        x.is_ferr = !stop_ok;
        x.data    = stop_ok ? d : last_data;
        x.ovr     = stop_ok && p;
        if (stop_ok) last_data = d;
        exp_q.push_back(x);
        rx = 0;
        tk(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tk(DIV);
        end
        rx = stop_ok;
        tk(DIV);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tk(1);
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (rst_n && (we_data_o || we_ctrl_o || ferr_o || overrun_o)) begin
            if (we_data_o) wcyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: got we=%b ctrl=%b ferr=%b ovr=%b expected none (cycle %0d)",
                         we_data_o, we_ctrl_o, ferr_o, overrun_o, cyc);
            end else begin
                e = exp_q.pop_front();
                check("we_data", we_data_o, !e.is_ferr);
                check("we_ctrl", we_ctrl_o, !e.is_ferr);
                check("ferr", ferr_o, e.is_ferr);
                check("overrun", overrun_o, e.ovr);
                check("data", data_o, e.data);
            end
        end
    end

    initial begin
        int busy_n, w0;
        logic [7:0] d;
        bit ok;
        tk(4);
        check("rst_data", data_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_pulses", {we_data_o, we_ctrl_o, ferr_o, overrun_o}, 0);
        rst_n = 1;
        tk(5);

        send_frame(8'hA5, 1, 0);
        tk(10);
        drain("drain_a5");

        w0 = wcyc.size();
        send_frame(8'h00, 1, 0);
        send_frame(8'hFF, 1, 0);
        tk(10);
        drain("drain_b2b");
        check("b2b_writes", wcyc.size() - w0, 2);
        if (wcyc.size() - w0 == 2) check_rng("b2b_spacing", wcyc[w0+1] - wcyc[w0], 158, 162);

        rx = 0;
        tk(4);
        rx = 1;
        busy_n = 0;
        for (int i = 0; i < 40; i++) begin
            tk(1);
            if (busy_o) busy_n++;
        end
        check_rng("glitch_busy", busy_n, 1, 11);
        check("glitch_idle", busy_o, 0);

        send_frame(8'h3C, 0, 0);
        tk(100);
        check("break_busy", busy_o, 1);
        rx = 1;
        tk(4);
        check("break_idle", busy_o, 0);
        drain("drain_ferr");
        send_frame(8'h55, 1, 0);
        tk(10);
        drain("drain_55");

        send_frame(8'h81, 1, 1);
        tk(10);
        drain("drain_81");
        pend = 0;

        rx = 0;
        tk(DIV);
        for (int i = 0; i < 4; i++) begin
            rx = 8'h5A >> i;
            tk(DIV);
        end
        rx = 1;
        tk(DIV / 2);
        rst_n = 0;
        tk(3);
        check("midrst_busy", busy_o, 0);
        check("midrst_data", data_o, 0);
        check("midrst_pulses", {we_data_o, we_ctrl_o, ferr_o, overrun_o}, 0);
        rst_n = 1;
        last_data = 8'h00;
        tk(200);
        check("postrst_busy", busy_o, 0);
        check("postrst_data", data_o, 0);
        send_frame(8'h12, 1, 0);
        tk(10);
        drain("drain_12");

        for (int k = 0; k < 30; k++) begin
            d  = 8'($urandom);
            ok = $urandom_range(0, 5) != 0;
            send_frame(d, ok, 1'($urandom));
            if (!ok) begin
                tk($urandom_range(0, 60));
                rx = 1;
                tk($urandom_range(3, 10));
            end else begin
                tk($urandom_range(0, 15));
            end
        end
        tk(10);
        drain("drain_rand");
        check("final_busy", busy_o, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
